// File: rtl/uoram_access_scheduler.sv
// Arbitrates LLC data-block and PLB posmap requests onto a single ORAM backend,
// issues the backend command and tracks the block's data beats to completion.
module uoram_access_scheduler #(
    parameter int ORAMU       = 32,
    parameter int BECMDWidth  = 2,
    parameter int BlockChunks = 8,
    parameter int StarveLimit = 4
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  LLCReqValid,
    output logic                  LLCReqReady,
    input  logic [BECMDWidth-1:0] LLCReqCmd,
    input  logic [ORAMU-1:0]      LLCReqPAddr,
    input  logic                  PLBReqValid,
    output logic                  PLBReqReady,
    input  logic                  PLBReqEvict,
    input  logic [ORAMU-1:0]      PLBReqPAddr,
    output logic                  BECmdValid,
    input  logic                  BECmdReady,
    output logic [BECMDWidth-1:0] BECmd,
    output logic [ORAMU-1:0]      BEPAddr,
    output logic                  SwitchReq,
    output logic                  DataBlockReq,
    output logic [BECMDWidth-1:0] Cmd,
    input  logic                  StoreBeat,
    input  logic                  LoadBeat,
    output logic                  LLCDone,
    output logic                  PLBDone,
    output logic                  Busy
);

    localparam int CntW = $clog2(BlockChunks) + 1;
    localparam int StvW = $clog2(StarveLimit + 1);

    localparam logic [BECMDWidth-1:0] CmdUpdate = BECMDWidth'(0);
    localparam logic [BECMDWidth-1:0] CmdAppend = BECMDWidth'(1);
    localparam logic [BECMDWidth-1:0] CmdRead   = BECMDWidth'(2);

    localparam logic [CntW-1:0] CntFull  = CntW'(BlockChunks);
    localparam logic [StvW-1:0] StvLimit = StvW'(StarveLimit);

    typedef enum logic [1:0] {IDLE, ISSUE, XFER, DONE} state_e;

    state_e                  state_q;
    logic [BECMDWidth-1:0]   cmd_q;
    logic [ORAMU-1:0]        addr_q;
    logic                    llc_q;
    logic [CntW-1:0]         cnt_q, cnt_d;
    logic [StvW-1:0]         starve_q;
    logic                    becmd_valid_q;
    logic                    llc_done_q, plb_done_q;

    logic                    idle_ok, grant_llc, grant_plb;
    logic [BECMDWidth-1:0]   grant_cmd;
    logic [ORAMU-1:0]        grant_addr;
    logic                    store_dir, beat, counting;

    // Grant is combinational so Ready/SwitchReq land in the cycle the request is seen.
    always_comb begin
        idle_ok    = Reset && (state_q == IDLE);
        grant_llc  = idle_ok && LLCReqValid && (!PLBReqValid || (starve_q == StvLimit));
        grant_plb  = idle_ok && PLBReqValid && !grant_llc;
        grant_cmd  = grant_llc ? LLCReqCmd : (PLBReqEvict ? CmdAppend : CmdRead);
        grant_addr = grant_llc ? LLCReqPAddr : PLBReqPAddr;
        store_dir  = (cmd_q == CmdUpdate) || (cmd_q == CmdAppend);
        beat       = store_dir ? StoreBeat : LoadBeat;
        counting   = (state_q == ISSUE) || (state_q == XFER);
        cnt_d      = cnt_q;
        if (counting && beat && (cnt_q != CntFull))
            cnt_d = cnt_q + CntW'(1);
    end

    assign LLCReqReady  = grant_llc;
    assign PLBReqReady  = grant_plb;
    assign SwitchReq    = grant_llc | grant_plb;
    assign DataBlockReq = grant_llc;
    assign Cmd          = SwitchReq ? grant_cmd : '0;
    assign BECmdValid   = becmd_valid_q;
    assign BECmd        = cmd_q;
    assign BEPAddr      = addr_q;
    assign LLCDone      = llc_done_q;
    assign PLBDone      = plb_done_q;
    assign Busy         = (state_q != IDLE);

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q       <= IDLE;
            cmd_q         <= '0;
            addr_q        <= '0;
            llc_q         <= 1'b0;
            cnt_q         <= '0;
            starve_q      <= '0;
            becmd_valid_q <= 1'b0;
            llc_done_q    <= 1'b0;
            plb_done_q    <= 1'b0;
        end else begin
            llc_done_q <= 1'b0;
            plb_done_q <= 1'b0;
            cnt_q      <= cnt_d;
            case (state_q)
                IDLE: begin
                    if (SwitchReq) begin
                        cmd_q         <= grant_cmd;
                        addr_q        <= grant_addr;
                        llc_q         <= grant_llc;
                        becmd_valid_q <= 1'b1;
                        cnt_q         <= '0;
                        state_q       <= ISSUE;
                        if (grant_llc)
                            starve_q <= '0;
                        else if (LLCReqValid && (starve_q != StvLimit))
                            starve_q <= starve_q + StvW'(1);
                    end
                end
                ISSUE: begin
                    if (becmd_valid_q && BECmdReady) begin
                        becmd_valid_q <= 1'b0;
                        state_q       <= XFER;
                    end
                end
                XFER: begin
                    // cnt_d already full covers beats that all arrived during ISSUE.
                    if (cnt_d == CntFull) begin
                        cnt_q      <= '0;
                        llc_done_q <= llc_q;
                        plb_done_q <= !llc_q;
                        state_q    <= DONE;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef SIMULATION
    always_ff @(posedge Clock) begin
        if (Reset && beat && ((state_q == IDLE) || (state_q == DONE)))
            $fatal(1, "uoram_access_scheduler: data beat with no active access");
    end
`endif

endmodule

// File: tb/tb_uoram_access_scheduler.sv
// Directed bench for uoram_access_scheduler: a table of single accesses plus
// hand-written sequences for early beats, mixed beats, starvation, reset and stall.
module tb_uoram_access_scheduler;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        LLCReqValid, LLCReqReady;
    logic [1:0]  LLCReqCmd;
    logic [31:0] LLCReqPAddr;
    logic        PLBReqValid, PLBReqReady, PLBReqEvict;
    logic [31:0] PLBReqPAddr;
    logic        BECmdValid, BECmdReady;
    logic [1:0]  BECmd;
    logic [31:0] BEPAddr;
    logic        SwitchReq, DataBlockReq;
    logic [1:0]  Cmd;
    logic        StoreBeat, LoadBeat;
    logic        LLCDone, PLBDone, Busy;

    int ncmp = 0;
    int nfail = 0;
    int cyc = 0;
    int sw_cnt = 0;

    uoram_access_scheduler dut (
        .Clock(Clock), .Reset(Reset),
        .LLCReqValid(LLCReqValid), .LLCReqReady(LLCReqReady),
        .LLCReqCmd(LLCReqCmd), .LLCReqPAddr(LLCReqPAddr),
        .PLBReqValid(PLBReqValid), .PLBReqReady(PLBReqReady),
        .PLBReqEvict(PLBReqEvict), .PLBReqPAddr(PLBReqPAddr),
        .BECmdValid(BECmdValid), .BECmdReady(BECmdReady),
        .BECmd(BECmd), .BEPAddr(BEPAddr),
        .SwitchReq(SwitchReq), .DataBlockReq(DataBlockReq), .Cmd(Cmd),
        .StoreBeat(StoreBeat), .LoadBeat(LoadBeat),
        .LLCDone(LLCDone), .PLBDone(PLBDone), .Busy(Busy)
    );

    always #5 Clock = ~Clock;
    always @(posedge Clock) cyc <= cyc + 1;
    always @(negedge Clock) if (SwitchReq === 1'b1) sw_cnt <= sw_cnt + 1;

    typedef struct {
        bit          llc;
        logic [1:0]  cmd;
        bit          evict;
        logic [31:0] addr;
        logic [1:0]  exp_cmd;
        bit          exp_dbr;
    } vec_t;

    vec_t vt[6];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge Clock);
        #1;
    endtask

    task automatic chk_zero(input string nm);
        chk(nm, 64'({LLCReqReady, PLBReqReady, BECmdValid, BECmd, BEPAddr, SwitchReq,
                     DataBlockReq, Cmd, LLCDone, PLBDone, Busy}), 64'(0));
    endtask

    // Full access from IDLE: one-cycle BECmdReady, then 8 back-to-back beats.
    task automatic run_vec(input vec_t v, output int gcyc);
        bit st;
        st = (v.exp_cmd < 2'd2);
        if (v.llc) begin
            LLCReqValid = 1'b1; LLCReqCmd = v.cmd; LLCReqPAddr = v.addr;
        end else begin
            PLBReqValid = 1'b1; PLBReqEvict = v.evict; PLBReqPAddr = v.addr;
        end
        #1;
        chk("grant_llc_ready", 64'(LLCReqReady), 64'(v.llc));
        chk("grant_plb_ready", 64'(PLBReqReady), 64'(!v.llc));
        chk("grant_switch", 64'(SwitchReq), 64'(1));
        chk("grant_datablock", 64'(DataBlockReq), 64'(v.exp_dbr));
        chk("grant_cmd", 64'(Cmd), 64'(v.exp_cmd));
        gcyc = cyc;
        tick;
        LLCReqValid = 1'b0; PLBReqValid = 1'b0;
        #1;
        chk("issue_valid", 64'(BECmdValid), 64'(1));
        chk("issue_becmd", 64'(BECmd), 64'(v.exp_cmd));
        chk("issue_addr", 64'(BEPAddr), 64'(v.addr));
        chk("issue_busy", 64'(Busy), 64'(1));
        chk("issue_switch", 64'(SwitchReq), 64'(0));
        BECmdReady = 1'b1;
        tick;
        BECmdReady = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (st) StoreBeat = 1'b1; else LoadBeat = 1'b1;
            #1;
            chk("xfer_no_done", 64'({LLCDone, PLBDone}), 64'(0));
            tick;
        end
        StoreBeat = 1'b0; LoadBeat = 1'b0;
        #1;
        chk("done_llc", 64'(LLCDone), 64'(v.llc));
        chk("done_plb", 64'(PLBDone), 64'(!v.llc));
        tick;
        chk("idle_after_done", 64'({Busy, LLCDone, PLBDone}), 64'(0));
    endtask

    initial begin
        int gc, prev;
        bit exp_l[10];
        bit mix[11];

        vt[0] = '{llc:1'b0, cmd:2'd0, evict:1'b0, addr:32'h10,       exp_cmd:2'd2, exp_dbr:1'b0};
        vt[1] = '{llc:1'b0, cmd:2'd0, evict:1'b1, addr:32'h44,       exp_cmd:2'd1, exp_dbr:1'b0};
        vt[2] = '{llc:1'b1, cmd:2'd0, evict:1'b0, addr:32'h100,      exp_cmd:2'd0, exp_dbr:1'b1};
        vt[3] = '{llc:1'b1, cmd:2'd1, evict:1'b1, addr:32'h20,       exp_cmd:2'd1, exp_dbr:1'b1};
        vt[4] = '{llc:1'b1, cmd:2'd2, evict:1'b0, addr:32'hDEADBEEF, exp_cmd:2'd2, exp_dbr:1'b1};
        vt[5] = '{llc:1'b1, cmd:2'd3, evict:1'b0, addr:32'hFFFFFFFF, exp_cmd:2'd3, exp_dbr:1'b1};
        exp_l = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        mix   = '{0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 0};

        Reset = 1'b0;
        LLCReqValid = 1'b0; LLCReqCmd = 2'd0; LLCReqPAddr = '0;
        PLBReqValid = 1'b0; PLBReqEvict = 1'b0; PLBReqPAddr = '0;
        BECmdReady = 1'b0; StoreBeat = 1'b0; LoadBeat = 1'b0;
        repeat (3) tick;
        chk_zero("reset_outputs");
        Reset = 1'b1;
        tick;

        // Table: back-to-back single accesses, grant spacing BlockChunks+3.
        prev = 0;
        for (int i = 0; i < 6; i++) begin
            run_vec(vt[i], gc);
            if (i > 0) chk("grant_spacing", 64'(gc - prev), 64'(11));
            prev = gc;
        end

        // All store beats arrive while the command is still stalled.
        LLCReqValid = 1'b1; LLCReqCmd = 2'd1; LLCReqPAddr = 32'h20;
        #1;
        chk("early_grant", 64'({LLCReqReady, SwitchReq, DataBlockReq}), 64'(3'b111));
        tick;
        LLCReqValid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            StoreBeat = 1'b1;
            #1;
            chk("early_issue_hold", 64'(BECmdValid), 64'(1));
            tick;
        end
        StoreBeat = 1'b0; BECmdReady = 1'b1;
        tick;
        BECmdReady = 1'b0;
        #1;
        chk("early_xfer", 64'({BECmdValid, Busy, LLCDone}), 64'(3'b010));
        tick;
        chk("early_done", 64'({LLCDone, PLBDone, Busy}), 64'(3'b101));
        tick;
        chk("early_idle", 64'(Busy), 64'(0));

        // LLC Read with wrong-direction store beats mixed in.
        LLCReqValid = 1'b1; LLCReqCmd = 2'd2; LLCReqPAddr = 32'h30;
        tick;
        LLCReqValid = 1'b0; BECmdReady = 1'b1;
        tick;
        BECmdReady = 1'b0;
        for (int i = 0; i < 11; i++) begin
            if (mix[i]) StoreBeat = 1'b1; else LoadBeat = 1'b1;
            #1;
            chk("mix_no_early_done", 64'(LLCDone), 64'(0));
            tick;
            StoreBeat = 1'b0; LoadBeat = 1'b0;
        end
        chk("mix_done", 64'(LLCDone), 64'(1));
        tick;

        // Both requesters valid continuously: starvation limit forces LLC every 5th grant.
        LLCReqValid = 1'b1; LLCReqCmd = 2'd2; LLCReqPAddr = 32'h40;
        PLBReqValid = 1'b1; PLBReqEvict = 1'b0; PLBReqPAddr = 32'h80;
        for (int g = 0; g < 10; g++) begin
            #1;
            chk("starve_llc_ready", 64'(LLCReqReady), 64'(exp_l[g]));
            chk("starve_plb_ready", 64'(PLBReqReady), 64'(!exp_l[g]));
            tick;
            BECmdReady = 1'b1;
            tick;
            BECmdReady = 1'b0;
            for (int i = 0; i < 8; i++) begin
                LoadBeat = 1'b1;
                tick;
            end
            LoadBeat = 1'b0;
            #1;
            chk("starve_done", 64'({LLCDone, PLBDone}), 64'({exp_l[g], !exp_l[g]}));
            chk("done_no_grant", 64'({LLCReqReady, PLBReqReady, SwitchReq}), 64'(0));
            tick;
        end
        LLCReqValid = 1'b0; PLBReqValid = 1'b0;

        // Reset in the middle of a transfer.
        LLCReqValid = 1'b1; LLCReqCmd = 2'd0; LLCReqPAddr = 32'h50;
        tick;
        LLCReqValid = 1'b0; BECmdReady = 1'b1;
        tick;
        BECmdReady = 1'b0;
        for (int i = 0; i < 5; i++) begin
            StoreBeat = 1'b1;
            tick;
        end
        StoreBeat = 1'b0; Reset = 1'b0;
        tick;
        chk_zero("midxfer_reset_outputs");
        Reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("post_reset_quiet", 64'({LLCDone, PLBDone, Busy}), 64'(0));
        end
        run_vec('{llc:1'b0, cmd:2'd0, evict:1'b1, addr:32'h60, exp_cmd:2'd1, exp_dbr:1'b0}, gc);

        // Backend stalls 20 cycles while a new PLB request waits.
        PLBReqValid = 1'b1; PLBReqEvict = 1'b0; PLBReqPAddr = 32'h70;
        #1;
        chk("stall_grant", 64'({PLBReqReady, SwitchReq}), 64'(2'b11));
        tick;
        PLBReqPAddr = 32'h99;
        for (int i = 0; i < 20; i++) begin
            #1;
            chk("stall_hold", 64'({BECmdValid, BECmd, BEPAddr}), 64'({1'b1, 2'd2, 32'h70}));
            chk("stall_no_regrant", 64'({SwitchReq, PLBReqReady}), 64'(0));
            tick;
        end
        PLBReqValid = 1'b0; BECmdReady = 1'b1;
        tick;
        BECmdReady = 1'b0;
        for (int i = 0; i < 8; i++) begin
            LoadBeat = 1'b1;
            tick;
        end
        LoadBeat = 1'b0;
        chk("stall_done", 64'({PLBDone, LLCDone}), 64'(2'b10));
        tick;
        #6;
        chk("switch_total", 64'(sw_cnt), 64'(21));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule

// File: doc/uoram_access_scheduler.md
UORAM_ACCESS_SCHEDULER -- requirements
Module: uoram_access_scheduler

Interface
REQ-001 Parameters (name, default, meaning):
- ORAMU, 32, program/posmap block address width.
- BECMDWidth, 2, backend command width; Update=0, Append=1, Read=2, ReadRmv=3.
- BlockChunks, 8, data beats per block transfer.
- StarveLimit, 4, maximum consecutive PLB grants while an LLC request waits.

REQ-002 Ports (name, direction, width, meaning):
- Clock, in, 1, sole clock; all logic on its rising edge.
- Reset, in, 1, synchronous, active-low reset.
- LLCReqValid, in, 1, LLC data-block request pending.
- LLCReqReady, out, 1, LLC request accepted this cycle.
- LLCReqCmd, in, BECMDWidth, LLC command.
- LLCReqPAddr, in, ORAMU, LLC block address.
- PLBReqValid, in, 1, PLB posmap request pending.
- PLBReqReady, out, 1, PLB request accepted this cycle.
- PLBReqEvict, in, 1, 1 = posmap evict (store), 0 = posmap refill (load).
- PLBReqPAddr, in, ORAMU, posmap block address.
- BECmdValid, out, 1, backend command valid.
- BECmdReady, in, 1, backend accepts the command.
- BECmd, out, BECMDWidth, backend command.
- BEPAddr, out, ORAMU, backend address.
- SwitchReq, out, 1, one-cycle pulse that configures the datapath.
- DataBlockReq, out, 1, 1 = data block, 0 = posmap block; valid with SwitchReq.
- Cmd, out, BECMDWidth, datapath command; valid with SwitchReq.
- StoreBeat, in, 1, one store beat transferred to the backend.
- LoadBeat, in, 1, one load beat transferred from the backend.
- LLCDone, out, 1, one-cycle pulse when an LLC access completes.
- PLBDone, out, 1, one-cycle pulse when a PLB access completes.
- Busy, out, 1, high in every state except IDLE.

Function
REQ-003 The FSM SHALL have the states IDLE, ISSUE, XFER and DONE.
REQ-004 In IDLE with a request present, the FSM SHALL grant one request, assert that requester's Ready for one cycle, latch the command, address and requester, pulse SwitchReq, and move to ISSUE in the same cycle.
REQ-005 Arbitration SHALL favour PLB; LLC SHALL win when only LLC is valid, or when both are valid and StarveCnt == StarveLimit.
- StarveCnt is a saturating counter.
- It SHALL increment on each PLB grant made while LLCReqValid=1.
- It SHALL clear on every LLC grant.
REQ-006 A PLB grant SHALL map to BECmd and Cmd = Append when PLBReqEvict=1, else Read, with DataBlockReq=0; an LLC grant SHALL pass LLCReqCmd through unchanged, with DataBlockReq=1.
REQ-007 In ISSUE, BECmdValid SHALL be 1 with BECmd and BEPAddr held stable; on BECmdValid&&BECmdReady the FSM SHALL move to XFER.
REQ-008 A beat counter of width log2(BlockChunks)+1 SHALL count the beats of the active access:
- StoreBeat for Update/Append; LoadBeat for Read/ReadRmv.
- Beats of the other direction SHALL be ignored.
- Beats SHALL be counted in both ISSUE and XFER, because the datapath may move data before command acceptance.
REQ-009 When the counter reaches BlockChunks in XFER, or on entry to XFER when it has already reached BlockChunks, the FSM SHALL move to DONE and clear the counter.
REQ-010 DONE SHALL last exactly one cycle:
- Pulse LLCDone or PLBDone, according to the latched requester.
- Return to IDLE.
- Accept no new request in that cycle.
REQ-011 Minimum grant-to-grant spacing SHALL be BlockChunks+3 cycles, given a one-cycle BECmdReady and back-to-back beats.
REQ-012 There SHALL be exactly one SwitchReq per access; SwitchReq SHALL never be asserted outside the grant cycle.
REQ-013 A counted beat arriving in IDLE or DONE SHALL be dropped; under SIMULATION it SHALL report an error and stop the simulation.
REQ-014 Requests SHALL hold Valid and payload until Ready; a Valid dropped before a grant SHALL cause no action.

Reset
REQ-015 While Reset=0 at a rising Clock edge, the block SHALL enter IDLE and clear StarveCnt, the beat counter, all latched fields and every output, whatever state or transfer is in progress.
REQ-016 The reset value of every output SHALL be 0, including BECmd, BEPAddr and Cmd; an interrupted access SHALL produce no Done pulse.

Verification
REQ-017 PLB refill at 0x10: expect PLBReqReady and SwitchReq in the grant cycle with DataBlockReq=0 and Cmd=Read; BECmd=Read, BEPAddr=0x10. After 8 LoadBeats, PLBDone pulses once and Busy returns to 0.
REQ-018 LLC Append at 0x20, with all 8 StoreBeats arriving before BECmdReady: on BECmdReady expect XFER then DONE in the next two cycles, and LLCDone=1.
REQ-019 LLC and PLB both valid continuously: expect grant order P,P,P,P,L,P,P,P,P,L, with StarveCnt reaching 4 before each L.
REQ-020 LLC Read with 3 StoreBeats interleaved among 8 LoadBeats: completion SHALL occur only on the 8th LoadBeat.
REQ-021 Reset=0 in XFER after 5 beats: all outputs 0 next cycle, no Done pulse; a new request after release completes normally with 8 beats.
REQ-022 BECmdReady held low for 20 cycles: BECmdValid, BECmd and BEPAddr stable throughout, and no second SwitchReq.
